dma_cycle_stealer: RTL and testbench
====================================

// Module: dma_cycle_stealer
// PURPOSE
//  Memory-mapped word-copy DMA engine that shares the drisc memory bus with the core by cycle stealing.
//  Sits between drisc (address_bus/data_bus_out/data_size/read/write, data_bus_in) and memory.
//  The core always has priority: DMA reads/writes only in cycles where the core issues no access.
//  The core configures it through a 16-byte register window; completion raises an interrupt line.
// PARAMETERS
//  BASE_ADDRESS  32'hFFFF_FF00  register window base; window = BASE_ADDRESS[31:4], 16 bytes
//  LEN_WIDTH     16             width of the word-count register (max LEN = 2^LEN_WIDTH-1)
// PORTS
//  clock         in   1   single clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high
//  cpu_address   in   32  core address_bus
//  cpu_data_out  in   32  core data_bus_out (write data)
//  cpu_data_size in   2   core data_size, passed to memory on core cycles
//  cpu_read      in   1   core read strobe
//  cpu_write     in   1   core write strobe
//  cpu_data_in   out  32  to core data_bus_in: register data on window hit, else mem_data_in
//  mem_address   out  32  memory address
//  mem_data_out  out  32  memory write data
//  mem_data_size out  2   memory access size (2'b10 = word on DMA cycles)
//  mem_read      out  1   memory read strobe
//  mem_write     out  1   memory write strobe
//  mem_data_in   in   32  memory read data, valid in the same cycle as mem_read
//  dma_interrupt out  1   = done & irq_enable, to drisc external_interrupt
// BEHAVIOUR
//  Registers (offset): 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL. CTRL bits: [0] start (W, reads 0),
//   [1] busy (RO), [2] done (W1C), [3] irq_enable (RW), [4] abort (W, reads 0); other bits read 0.
//  hit = (cpu_address[31:4] == BASE_ADDRESS[31:4]) & (cpu_read | cpu_write); offset = cpu_address[3:2].
//  Register writes on hit & cpu_write take effect at the clock edge; full 32 bits, cpu_data_size ignored.
//  SRC/DST writes force bits [1:0] to 0. LEN takes cpu_data_out[LEN_WIDTH-1:0].
//  Register reads are combinational in the same cycle (zero latency) on cpu_data_in.
//  On a window hit, mem_read and mem_write stay 0 (the access is not forwarded to memory).
//  bus_free = ~cpu_read & ~cpu_write. Any core access, including a window hit, blocks DMA for that cycle.
//  Core cycle (not hit): mem_* = cpu_* passthrough, combinational.
//  Idle cycle with no DMA action: mem_read = mem_write = 0; mem_address/mem_data_out don't-care.
//  FSM states IDLE, RD, WR. busy = (state != IDLE).
//   IDLE: start=1 with LEN!=0 -> RD, done cleared. start=1 with LEN==0 -> done set, stay IDLE.
//   RD: on bus_free: mem_read=1, mem_address=SRC, data_size=word; buf<=mem_data_in; SRC+=4 -> WR.
//       Otherwise hold RD.
//   WR: on bus_free: mem_write=1, mem_address=DST, mem_data_out=buf; DST+=4; LEN-=1.
//       If LEN==1 -> IDLE and done set; else -> RD. Otherwise hold WR.
//  Address arithmetic is modulo 2^32 (0xFFFF_FFFC+4 wraps to 0). SRC/DST/LEN are live and readable mid-transfer.
//  While busy: writes to SRC/DST/LEN and start are ignored; irq_enable, done-W1C and abort are honoured.
//  abort=1 while busy -> IDLE next edge, done not set, SRC/DST/LEN keep current values. Abort in IDLE: no effect.
//  abort and start in the same write: abort wins (stays/returns IDLE).
//  done W1C in the same cycle as completion: set wins, done stays 1.
//  Reset: state=IDLE; SRC=DST=buf=0; LEN=0; done=irq_enable=0; dma_interrupt=0.
//   mem_read = mem_write = 0 unless the core strobes. Reset mid-transfer drops the transfer with no further bus cycles.
//  Throughput: 2 bus-free cycles per word; at most one DMA bus access per cycle.
// TESTING
//  1 Reset: assert reset 2 cycles mid-transfer -> all regs read 0, no mem strobes, dma_interrupt=0.
//  2 Copy: SRC=0x100, DST=0x200, LEN=3, CTRL=0x9, core idle
//      -> 6 cycles alternating rd 0x100/wr 0x200 ... rd 0x108/wr 0x208; data matches source.
//      -> done=1, dma_interrupt=1; CTRL reads 0xC.
//  3 Stealing: core reads every other cycle during 2-word copy
//      -> core accesses pass unmodified; DMA only in gaps; copy completes in 8 cycles.
//  4 Edge: LEN=0 start -> done=1 immediately, no strobes.
//      SRC=0xFFFF_FFFE -> reads back 0xFFFF_FFFC; a 2-word copy then reads 0xFFFF_FFFC, 0x0.
//  5 Abort/ignore: while busy, write LEN=9 (ignored), then CTRL=0x10 -> IDLE next edge, done=0, no more strobes.
//  6 W1C race: write CTRL=0x4 in the completing WR cycle -> done=1; a later CTRL=0x4 write -> done=0, irq drops.

Source files
------------

// File: rtl/dma_cycle_stealer.sv
// Word-copy DMA engine that borrows idle cycles on the core memory bus.
// The core is always served first; DMA reads and writes only run in cycles where the core leaves the bus idle.
module dma_cycle_stealer #(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_FF00,
  parameter int          LEN_WIDTH    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_data_out,
  input  logic [1:0]  cpu_data_size,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_data_in,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic [1:0]  mem_data_size,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data_in,
  output logic        dma_interrupt
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t               state, state_nxt;
  logic [31:0]          src, dst, data_buf;
  logic [LEN_WIDTH-1:0] len;
  logic                 done, irq_enable;
  logic                 hit, wr_hit, bus_free, busy, ctrl_wr, start, abort;
  logic                 rd_fire, wr_fire, done_set, go;
  logic [1:0]           offset;

  assign hit      = (cpu_address[31:4] == BASE_ADDRESS[31:4]) & (cpu_read | cpu_write);
  assign wr_hit   = hit & cpu_write;
  assign offset   = cpu_address[3:2];
  assign bus_free = ~cpu_read & ~cpu_write;
  assign busy     = (state != IDLE);
  assign ctrl_wr  = wr_hit & (offset == 2'd3);
  assign start    = ctrl_wr & cpu_data_out[0];
  assign abort    = ctrl_wr & cpu_data_out[4];
  assign dma_interrupt = done & irq_enable;

  always_comb begin
    state_nxt = state;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    done_set  = 1'b0;
    go        = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        if (len != '0) begin
          go        = 1'b1;
          state_nxt = RD;
        end else begin
          done_set  = 1'b1;
        end
      end
      RD: if (abort) state_nxt = IDLE;
          else if (bus_free && !reset) begin
            rd_fire   = 1'b1;
            state_nxt = WR;
          end
      WR: if (abort) state_nxt = IDLE;
          else if (bus_free && !reset) begin
            wr_fire = 1'b1;
            if (len == LEN_WIDTH'(1)) begin
              state_nxt = IDLE;
              done_set  = 1'b1;
            end else begin
              state_nxt = RD;
            end
          end
      default: state_nxt = IDLE;
    endcase
  end

  // Core cycles pass straight through; window hits are absorbed here.
  always_comb begin
    mem_address   = cpu_address;
    mem_data_out  = cpu_data_out;
    mem_data_size = cpu_data_size;
    mem_read      = cpu_read & ~hit;
    mem_write     = cpu_write & ~hit;
    if (rd_fire) begin
      mem_address   = src;
      mem_data_size = 2'b10;
      mem_read      = 1'b1;
    end else if (wr_fire) begin
      mem_address   = dst;
      mem_data_out  = data_buf;
      mem_data_size = 2'b10;
      mem_write     = 1'b1;
    end
  end

  always_comb begin
    cpu_data_in = mem_data_in;
    if (hit) begin
      case (offset)
        2'd0:    cpu_data_in = src;
        2'd1:    cpu_data_in = dst;
        2'd2:    cpu_data_in = 32'(len);
        default: cpu_data_in = {28'd0, irq_enable, done, busy, 1'b0};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      data_buf   <= '0;
      done       <= 1'b0;
      irq_enable <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_hit && !busy) begin
        case (offset)
          2'd0:    src <= {cpu_data_out[31:2], 2'b00};
          2'd1:    dst <= {cpu_data_out[31:2], 2'b00};
          2'd2:    len <= cpu_data_out[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (rd_fire) begin
        data_buf <= mem_data_in;
        src      <= src + 32'd4;
      end
      if (wr_fire) begin
        dst <= dst + 32'd4;
        len <= len - 1'b1;
      end
      if (ctrl_wr) irq_enable <= cpu_data_out[3];
      // Completion beats a simultaneous clear.
      if (done_set)                           done <= 1'b1;
      else if (go || (ctrl_wr && cpu_data_out[2])) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_cycle_stealer.sv
// Directed bench for dma_cycle_stealer: memory model on the bus, DMA bus events logged per cycle.
module tb_dma_cycle_stealer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clock, reset;
  logic [31:0] cpu_address, cpu_data_out, cpu_data_in;
  logic [1:0]  cpu_data_size, mem_data_size;
  logic        cpu_read, cpu_write, mem_read, mem_write, dma_interrupt;
  logic [31:0] mem_address, mem_data_out, mem_data_in;

  logic [31:0] mem [0:1023];
  int n_cmp = 0, n_bad = 0;

  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} ev_t;
  ev_t evq[$];

  dma_cycle_stealer #(.BASE_ADDRESS(BASE), .LEN_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_data_size(cpu_data_size),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_data_in(cpu_data_in),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_size(mem_data_size),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_in(mem_data_in),
    .dma_interrupt(dma_interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_data_in = mem[mem_address[11:2]];
  always @(posedge clock) if (mem_write) mem[mem_address[11:2]] <= mem_data_out;

  // Log every memory strobe issued while the core leaves the bus idle.
  always @(negedge clock)
    if ((mem_read || mem_write) && !cpu_read && !cpu_write)
      evq.push_back('{wr: mem_write, addr: mem_address, data: mem_data_out});

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] d);
    cpu_address = BASE | 32'(off); cpu_data_out = d; cpu_write = 1'b1;
    @(posedge clock); #1;
    cpu_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [31:0] d);
    cpu_address = BASE | 32'(off); cpu_read = 1'b1;
    #2 d = cpu_data_in;
    @(posedge clock); #1;
    cpu_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    bus_wr(4'h0, 32'h0000_0A00); bus_wr(4'h4, 32'h0000_0B00);
    bus_wr(4'h8, 32'd5);         bus_wr(4'hC, 32'h9);
    idle(3);
    reset = 1'b1; evq.delete();
    idle(2);
    reset = 1'b0;
    idle(3);
    n_cmp++; if (evq.size() != 0) begin n_bad++; $display("FAIL reset_strobes got %0d want 0", evq.size()); end
    n_cmp++; if (dma_interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", dma_interrupt); end
    for (int i = 0; i < 4; i++) begin
      reg_rd(4'(i*4), d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_reg%0d got %h want 0", i, d); end
    end
  endtask

  task automatic test_copy();
    logic [31:0] d;
    bus_wr(4'h0, 32'h100); bus_wr(4'h4, 32'h200); bus_wr(4'h8, 32'd3);
    cpu_address = BASE | 32'hC; cpu_data_out = 32'h9; cpu_write = 1'b1;
    #1;
    n_cmp++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_bad++; $display("FAIL hit_forward got r%b w%b want r0 w0", mem_read, mem_write); end
    @(posedge clock); #1; cpu_write = 1'b0;
    evq.delete();
    idle(6);
    n_cmp++; if (evq.size() != 6) begin n_bad++; $display("FAIL copy_count got %0d want 6", evq.size()); end
    for (int i = 0; i < 6 && i < evq.size(); i++) begin
      logic [31:0] ea;
      ea = (i % 2 == 0) ? 32'h100 + 32'(4*(i/2)) : 32'h200 + 32'(4*(i/2));
      n_cmp++;
      if (evq[i].wr !== (i % 2 == 1) || evq[i].addr !== ea) begin
        n_bad++; $display("FAIL copy_ev%0d got wr%b %h want wr%0d %h", i, evq[i].wr, evq[i].addr, i % 2, ea);
      end
      if (i % 2 == 1) begin
        n_cmp++; if (evq[i].data !== 32'hC0DE_0040 + 32'(i/2)) begin n_bad++; $display("FAIL copy_data%0d got %h want %h", i, evq[i].data, 32'hC0DE_0040 + 32'(i/2)); end
      end
    end
    n_cmp++; if (mem[130] !== 32'hC0DE_0042) begin n_bad++; $display("FAIL copy_mem got %h want c0de0042", mem[130]); end
    n_cmp++; if (dma_interrupt !== 1'b1) begin n_bad++; $display("FAIL copy_irq got %b want 1", dma_interrupt); end
    reg_rd(4'hC, d);
    n_cmp++; if (d !== 32'hC) begin n_bad++; $display("FAIL copy_ctrl got %h want c", d); end
    reg_rd(4'h0, d);
    n_cmp++; if (d !== 32'h10C) begin n_bad++; $display("FAIL copy_src got %h want 10c", d); end
    reg_rd(4'h8, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL copy_len got %h want 0", d); end
  endtask

  task automatic test_steal();
    logic [31:0] d;
    bus_wr(4'hC, 32'h4);
    bus_wr(4'h0, 32'h300); bus_wr(4'h4, 32'h400); bus_wr(4'h8, 32'd2); bus_wr(4'hC, 32'h1);
    evq.delete();
    for (int k = 0; k < 8; k++) begin
      cpu_address = 32'h40; cpu_data_size = 2'b01; cpu_read = (k % 2 == 0);
      #2;
      if (k % 2 == 0) begin
        n_cmp++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h40 || mem_data_size !== 2'b01 || cpu_data_in !== 32'hC0DE_0010) begin
          n_bad++; $display("FAIL steal_pass%0d got r%b w%b a%h s%b d%h want r1 w0 a00000040 s01 dc0de0010", k, mem_read, mem_write, mem_address, mem_data_size, cpu_data_in);
        end
      end
      @(posedge clock); #1;
    end
    cpu_read = 1'b0; cpu_data_size = 2'b00;
    n_cmp++; if (evq.size() != 4) begin n_bad++; $display("FAIL steal_count got %0d want 4", evq.size()); end
    if (evq.size() == 4) begin
      n_cmp++;
      if (evq[0].addr !== 32'h300 || evq[1].addr !== 32'h400 || evq[2].addr !== 32'h304 || evq[3].addr !== 32'h404 || !evq[3].wr) begin
        n_bad++; $display("FAIL steal_addrs got %h %h %h %h want 300 400 304 404", evq[0].addr, evq[1].addr, evq[2].addr, evq[3].addr);
      end
    end
    reg_rd(4'hC, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL steal_ctrl got %h want 4", d); end
    n_cmp++; if (mem[257] !== 32'hC0DE_00C1) begin n_bad++; $display("FAIL steal_mem got %h want c0de00c1", mem[257]); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    bus_wr(4'hC, 32'h4);
    bus_wr(4'h8, 32'd0); bus_wr(4'hC, 32'h1);
    evq.delete();
    idle(2);
    n_cmp++; if (evq.size() != 0) begin n_bad++; $display("FAIL len0_strobes got %0d want 0", evq.size()); end
    reg_rd(4'hC, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL len0_ctrl got %h want 4", d); end
    bus_wr(4'hC, 32'h4);
    bus_wr(4'h0, 32'hFFFF_FFFE);
    reg_rd(4'h0, d);
    n_cmp++; if (d !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL src_align got %h want fffffffc", d); end
    bus_wr(4'h4, 32'h500); bus_wr(4'h8, 32'd2); bus_wr(4'hC, 32'h1);
    evq.delete();
    idle(4);
    n_cmp++; if (evq.size() != 4) begin n_bad++; $display("FAIL wrap_count got %0d want 4", evq.size()); end
    if (evq.size() == 4) begin
      n_cmp++; if (evq[0].addr !== 32'hFFFF_FFFC || evq[2].addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h %h want fffffffc 0", evq[0].addr, evq[2].addr); end
    end
    n_cmp++; if (mem[320] !== 32'hC0DE_03FF || mem[321] !== 32'hC0DE_0000) begin n_bad++; $display("FAIL wrap_data got %h %h want c0de03ff c0de0000", mem[320], mem[321]); end
    reg_rd(4'h0, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL wrap_src got %h want 4", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    bus_wr(4'hC, 32'h4);
    bus_wr(4'h0, 32'h600); bus_wr(4'h4, 32'h700); bus_wr(4'h8, 32'd4); bus_wr(4'hC, 32'h1);
    idle(2);
    bus_wr(4'h8, 32'd9);
    reg_rd(4'h8, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL busy_len got %h want 3", d); end
    bus_wr(4'hC, 32'h10);
    evq.delete();
    idle(4);
    n_cmp++; if (evq.size() != 0) begin n_bad++; $display("FAIL abort_strobes got %0d want 0", evq.size()); end
    reg_rd(4'hC, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL abort_ctrl got %h want 0", d); end
    reg_rd(4'h0, d);
    n_cmp++; if (d !== 32'h604) begin n_bad++; $display("FAIL abort_src got %h want 604", d); end
    reg_rd(4'h4, d);
    n_cmp++; if (d !== 32'h704) begin n_bad++; $display("FAIL abort_dst got %h want 704", d); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    bus_wr(4'hC, 32'h4);
    bus_wr(4'h0, 32'h800); bus_wr(4'h4, 32'h900); bus_wr(4'h8, 32'd1); bus_wr(4'hC, 32'h9);
    idle(1);
    // Transfer now sits in its final write; the clear lands there and stalls it one cycle.
    bus_wr(4'hC, 32'hC);
    idle(1);
    reg_rd(4'hC, d);
    n_cmp++; if (d !== 32'hC) begin n_bad++; $display("FAIL race_ctrl got %h want c", d); end
    n_cmp++; if (dma_interrupt !== 1'b1) begin n_bad++; $display("FAIL race_irq got %b want 1", dma_interrupt); end
    n_cmp++; if (mem[576] !== 32'hC0DE_0200) begin n_bad++; $display("FAIL race_mem got %h want c0de0200", mem[576]); end
    bus_wr(4'hC, 32'hC);
    n_cmp++; if (dma_interrupt !== 1'b0) begin n_bad++; $display("FAIL clear_irq got %b want 0", dma_interrupt); end
    reg_rd(4'hC, d);
    n_cmp++; if (d !== 32'h8) begin n_bad++; $display("FAIL clear_ctrl got %h want 8", d); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    reset = 1'b1; cpu_address = '0; cpu_data_out = '0; cpu_data_size = '0;
    cpu_read = 1'b0; cpu_write = 1'b0;
    test_reset();
    test_copy();
    test_steal();
    test_edge();
    test_abort();
    test_w1c_race();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
